bert_test_controller: RTL and testbench

// - Sequences one bit-error-ratio measurement over the PRBS generator/checker datapath.
// - Per run: seeds the generator, clears the checker, waits for pattern lock, then counts

---
 rtl/bert_pkg.sv | 21 ++
 rtl/bert_sat_counter.sv | 31 +++
 rtl/bert_test_controller.sv | 149 ++++++++++++++
 tb/tb_bert_test_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bert_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bert_pkg : shared types and default constants for the BERT control |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package bert_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEED    = 3'd1,
    S_SYNC    = 3'd2,
    S_MEASURE = 3'd3,
    S_DONE    = 3'd4
  } bert_state_e;

  localparam int c_err_w    = 8;
  localparam int c_sync_len = 16;
  localparam int c_loss_len = 8;
  localparam int c_sync_tmo = 1024;
  localparam int c_relock_w = 4;
endpackage
`default_nettype wire

// File: rtl/bert_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bert_sat_counter : up-counter that sticks at all-ones, sync clear  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module bert_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);
  logic [W-1:0] r_count;

  assign count = r_count;
  assign sat   = &r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && !sat) begin
      r_count <= r_count + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/bert_test_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bert_test_controller : sequences one PRBS bit-error-ratio run      |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module bert_test_controller
  import bert_pkg::*;
#(
  parameter int ERR_W    = c_err_w,
  parameter int SYNC_LEN = c_sync_len,
  parameter int LOSS_LEN = c_loss_len,
  parameter int SYNC_TMO = c_sync_tmo
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [31:0]           window_len,
  input  logic                  bit_valid,
  input  logic                  bit_error,
  output logic                  gen_load,
  output logic                  chk_clear,
  output logic                  run_en,
  output logic                  busy,
  output logic                  done,
  output logic                  sync_fail,
  output logic [c_relock_w-1:0] relock_cnt,
  output logic [31:0]           bit_count,
  output logic [ERR_W-1:0]      total_error
);
  localparam int OK_W  = $clog2(SYNC_LEN + 1);
  localparam int ERR_RUN_W = $clog2(LOSS_LEN + 1);
  localparam int TMO_W = $clog2(SYNC_TMO + 1);

  bert_state_e          r_state, w_next;
  logic [OK_W-1:0]      r_okrun, w_ok_next;
  logic [ERR_RUN_W-1:0] r_errrun, w_err_next;
  logic [TMO_W-1:0]     r_tmo;
  logic [31:0]          r_win, r_bit_count;
  logic                 r_sync_fail;
  logic                 w_tmo_hit, w_lock, w_win_end, w_loss, w_start_go;
  logic                 w_err_sat, w_relock_sat, w_err_inc, w_relock_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_ok_next  = r_okrun;
    w_err_next = r_errrun;
    if (bit_valid) begin
      w_ok_next  = bit_error ? '0 : r_okrun + 1'b1;
      w_err_next = bit_error ? r_errrun + 1'b1 : '0;
    end
    w_tmo_hit  = (r_tmo == TMO_W'(SYNC_TMO - 1));
    w_lock     = (w_ok_next == OK_W'(SYNC_LEN));
    w_win_end  = bit_valid && ((r_bit_count + 32'd1) == r_win);
    w_loss     = bit_valid && bit_error && (w_err_next == ERR_RUN_W'(LOSS_LEN));
    w_start_go = start && !abort && (r_state == S_IDLE || r_state == S_DONE);
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_SEED;
      S_SEED:         w_next = S_SYNC;
      // Timeout is checked first so a lock on the final cycle still fails.
      S_SYNC: begin
        if (w_tmo_hit)   w_next = S_DONE;
        else if (w_lock) w_next = S_MEASURE;
      end
      S_MEASURE: begin
        if (w_win_end)   w_next = S_DONE;
        else if (w_loss) w_next = S_SYNC;
      end
      default:           w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;

    gen_load     = (r_state == S_SEED);
    chk_clear    = (r_state == S_SEED);
    run_en       = (r_state == S_SYNC) || (r_state == S_MEASURE);
    busy         = (r_state == S_SEED) || run_en;
    done         = (r_state == S_DONE);
    w_err_inc    = !abort && (r_state == S_MEASURE) && bit_valid && bit_error && !w_err_sat;
    w_relock_inc = !abort && (r_state == S_MEASURE) && w_loss && !w_win_end && !w_relock_sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_okrun     <= '0;
      r_errrun    <= '0;
      r_tmo       <= '0;
      r_win       <= '0;
      r_bit_count <= '0;
      r_sync_fail <= 1'b0;
    end else if (!abort) begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_bit_count <= '0;
            r_sync_fail <= 1'b0;
            r_win       <= (window_len == 32'd0) ? 32'd1 : window_len;
          end
        end
        S_SEED: begin
          r_okrun  <= '0;
          r_errrun <= '0;
          r_tmo    <= '0;
        end
        S_SYNC: begin
          r_okrun  <= w_ok_next;
          r_errrun <= '0;
          r_tmo    <= r_tmo + 1'b1;
          if (w_tmo_hit) r_sync_fail <= 1'b1;
        end
        S_MEASURE: begin
          r_errrun <= w_err_next;
          if (bit_valid) r_bit_count <= r_bit_count + 32'd1;
          if (w_loss && !w_win_end) begin
            r_okrun <= '0;
            r_tmo   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  bert_sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_start_go),
    .inc   (w_err_inc),
    .count (total_error),
    .sat   (w_err_sat)
  );

  bert_sat_counter #(.W(c_relock_w)) u_relock_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_start_go),
    .inc   (w_relock_inc),
    .count (relock_cnt),
    .sat   (w_relock_sat)
  );

  assign bit_count = r_bit_count;
  assign sync_fail = r_sync_fail;
endmodule
`default_nettype wire

// File: tb/tb_bert_test_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_bert_test_controller : directed scoreboard bench for BERT ctrl  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_bert_test_controller;
  logic        clk = 1'b0;
  logic        rst_n, start, abort, bit_valid, bit_error;
  logic [31:0] window_len;
  logic        gen_load, chk_clear, run_en, busy, done, sync_fail;
  logic [3:0]  relock_cnt;
  logic [31:0] bit_count;
  logic [7:0]  total_error;

  int n_checks = 0;
  int n_errors = 0;
  int bit_idx  = 0;
  int mode     = 0;
  int used;

  typedef struct {
    string       tag;
    int          bits;
    logic [31:0] bc;
    logic [7:0]  te;
    logic [3:0]  rc;
    logic        sf;
  } exp_t;
  exp_t sb[$];

  bert_test_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .window_len(window_len), .bit_valid(bit_valid), .bit_error(bit_error),
    .gen_load(gen_load), .chk_clear(chk_clear), .run_en(run_en), .busy(busy),
    .done(done), .sync_fail(sync_fail), .relock_cnt(relock_cnt),
    .bit_count(bit_count), .total_error(total_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Error pattern indexed from the first SYNC cycle; the first 16 bits are the lock run.
  function automatic logic err_of(input int m, input int i);
    int k = i - 15;
    case (m)
      1: return (i >= 16) && (k % 10 == 0);
      2: return (i >= 16) && (k % 10 >= 1) && (k % 10 <= 3);
      3: return 1'b1;
      4: return (i >= 58) && (i < 66);
      default: return 1'b0;
    endcase
  endfunction

  task automatic stream(input int n);
    for (int j = 0; j < n; j++) begin
      bit_valid = 1'b1;
      bit_error = err_of(mode, bit_idx);
      tick();
      bit_idx++;
    end
    bit_valid = 1'b0;
    bit_error = 1'b0;
  endtask

  task automatic stream_to_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      stream(1);
      n++;
    end
    if (!done) check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic start_run(input logic [31:0] w, input int m);
    mode       = m;
    window_len = w;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    check("seed_gen_load", {31'd0, gen_load}, 32'd1);
    check("seed_chk_clear", {31'd0, chk_clear}, 32'd1);
    check("seed_cleared_bc", bit_count, 32'd0);
    tick();
    check("sync_run_en", {31'd0, run_en}, 32'd1);
    check("sync_gen_load_off", {31'd0, gen_load}, 32'd0);
    bit_idx = 0;
  endtask

  task automatic push(input string tag, input int bits, input logic [31:0] bc,
                      input logic [7:0] te, input logic [3:0] rc, input logic sf);
    exp_t e;
    e.tag = tag; e.bits = bits; e.bc = bc; e.te = te; e.rc = rc; e.sf = sf;
    sb.push_back(e);
  endtask

  task automatic pop_compare(input int n);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, "_cycles"}, n, e.bits);
    check({e.tag, "_done"}, {31'd0, done}, 32'd1);
    check({e.tag, "_bit_count"}, bit_count, e.bc);
    check({e.tag, "_total_error"}, {24'd0, total_error}, {24'd0, e.te});
    check({e.tag, "_relock"}, {28'd0, relock_cnt}, {28'd0, e.rc});
    check({e.tag, "_sync_fail"}, {31'd0, sync_fail}, {31'd0, e.sf});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    bit_valid = 1'b0; bit_error = 1'b0; window_len = 32'd0;
    #12;
    check("rst_outputs", {26'd0, gen_load, chk_clear, run_en, busy, done, sync_fail}, 32'd0);
    check("rst_counts", bit_count | {24'd0, total_error} | {28'd0, relock_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Clean stream, window 100, then hold in DONE.
    push("clean", 116, 32'd100, 8'd0, 4'd0, 1'b0);
    start_run(32'd100, 0);
    stream_to_done(3000, used);
    pop_compare(used);
    stream(3);
    check("done_hold_bc", bit_count, 32'd100);
    check("done_hold", {31'd0, done}, 32'd1);

    // Error every tenth measured bit.
    push("every10", 1016, 32'd1000, 8'd100, 4'd0, 1'b0);
    start_run(32'd1000, 1);
    stream_to_done(3000, used);
    pop_compare(used);

    // 300 errors saturate an 8-bit count.
    push("saturate", 1016, 32'd1000, 8'd255, 4'd0, 1'b0);
    start_run(32'd1000, 2);
    stream_to_done(3000, used);
    pop_compare(used);

    // Never locks: timeout after 1024 SYNC cycles.
    push("timeout", 1024, 32'd0, 8'd0, 4'd0, 1'b1);
    start_run(32'd100, 3);
    stream_to_done(3000, used);
    pop_compare(used);

    // Zero window behaves as one bit.
    push("win0", 17, 32'd1, 8'd0, 4'd0, 1'b0);
    start_run(32'd0, 0);
    stream_to_done(3000, used);
    pop_compare(used);

    // Loss of lock after 50 counted bits, relock, then finish the window.
    push("relock", 49, 32'd100, 8'd8, 4'd1, 1'b0);
    start_run(32'd100, 4);
    stream(66);
    check("loss_bc", bit_count, 32'd50);
    check("loss_relock", {28'd0, relock_cnt}, 32'd1);
    check("loss_in_sync", {31'd0, run_en & busy}, 32'd1);
    stream(16);
    check("resync_bc_frozen", bit_count, 32'd50);
    start = 1'b1;
    stream(1);
    start = 1'b0;
    check("resume_bc", bit_count, 32'd51);
    stream_to_done(3000, used);
    pop_compare(used);

    // Abort (with simultaneous start) mid-measure holds counts.
    start_run(32'd100, 0);
    stream(56);
    check("pre_abort_bc", bit_count, 32'd40);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("abort_busy", {30'd0, busy, done}, 32'd0);
    check("abort_bc_held", bit_count, 32'd40);
    tick();
    check("abort_idle", {30'd0, busy, run_en}, 32'd0);
    push("after_abort", 36, 32'd20, 8'd0, 4'd0, 1'b0);
    start_run(32'd20, 0);
    stream_to_done(3000, used);
    pop_compare(used);

    // Asynchronous reset mid-measure.
    start_run(32'd100, 1);
    stream(46);
    check("pre_rst_te", {24'd0, total_error}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_flags", {26'd0, gen_load, chk_clear, run_en, busy, done, sync_fail}, 32'd0);
    check("async_rst_bc", bit_count, 32'd0);
    check("async_rst_te", {24'd0, total_error}, 32'd0);
    #3 rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
